// File: rtl/word_pair_pkg.sv
// Shared types and constants for the word-pair packer.
package word_pair_pkg;

  localparam int unsigned PAIR_LANES = 2;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} pack_state_t;

  localparam logic [1:0] KEEP_ONE  = 2'b01;
  localparam logic [1:0] KEEP_BOTH = 2'b11;

endpackage

// File: rtl/word_pair_packer.sv
// Packs a valid/ready stream of single words into two-lane pairs; lane 0 is
// the earlier word, odd burst tails are emitted as a single zero-padded lane.
module word_pair_packer
  import word_pair_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data [PAIR_LANES],
  output logic [1:0]       out_keep,
  output logic             out_last,
  output logic [CNT_W-1:0] pair_cnt
);

  pack_state_t state;
  logic        acc;
  logic        pop;

  // No skid buffer: a full pair only makes room when it leaves this cycle.
  assign in_ready = (state != FULL) | out_ready;
  assign acc      = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_keep    <= '0;
      out_last    <= 1'b0;
      out_data[0] <= '0;
      out_data[1] <= '0;
    end else begin
      if (pop) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        out_keep  <= '0;
        out_last  <= 1'b0;
      end
      // Accept overrides the pop defaults above; acc in FULL implies pop, so
      // FULL+acc is handled exactly like EMPTY+acc.
      if (acc) begin
        if (state == HALF) begin
          out_data[1] <= in_data;
          out_keep    <= KEEP_BOTH;
          out_last    <= in_last;
          out_valid   <= 1'b1;
          state       <= FULL;
        end else begin
          out_data[0] <= in_data;
          if (in_last) begin
            out_data[1] <= '0;
            out_keep    <= KEEP_ONE;
            out_last    <= 1'b1;
            out_valid   <= 1'b1;
            state       <= FULL;
          end else begin
            state <= HALF;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= '0;
    end else if (pop && (pair_cnt != '1)) begin
      pair_cnt <= pair_cnt + 1'b1;
    end
  end

  a_keep_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> (out_keep == 2'b00));
  a_keep_valid : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ((out_keep == KEEP_ONE) || (out_keep == KEEP_BOTH)));
  a_single_last : assert property (@(posedge clk) disable iff (!rst_n)
    (out_keep == KEEP_ONE) |-> out_last);

endmodule

// File: tb/tb_word_pair_packer.sv
// Directed bench for word_pair_packer, with a CNT_W=4 copy for counter saturation.
module tb_word_pair_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data [2];
  logic [1:0]  out_keep;
  logic        out_last;
  logic [15:0] pair_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_data4 [2];
  logic [1:0]  out_keep4;
  logic        out_last4;
  logic [3:0]  pair_cnt4;

  int checks;
  int failures;

  word_pair_packer #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .pair_cnt(pair_cnt)
  );

  word_pair_packer #(.DW(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_keep(out_keep4),
    .out_last(out_last4), .pair_cnt(pair_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] keep, input logic last);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_d0"}, 64'(out_data[0]), 64'(d0));
    chk({tag, "_d1"}, 64'(out_data[1]), 64'(d1));
    chk({tag, "_keep"}, 64'(out_keep), 64'(keep));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_keep", 64'(out_keep), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_cnt", 64'(pair_cnt), 64'd0);
    chk("rst_d0", 64'(out_data[0]), 64'd0);
    chk("rst_d1", 64'(out_data[1]), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Simple pair
    in_valid = 1'b1; in_data = 32'h1111_1111; in_last = 1'b0;
    tick();
    chk("p1_half_valid", 64'(out_valid), 64'd0);
    in_data = 32'h2222_2222;
    tick();
    in_valid = 1'b0;
    chk_pair("p1", 32'h1111_1111, 32'h2222_2222, 2'b11, 1'b0);
    chk("p1_cnt_before_pop", 64'(pair_cnt), 64'd0);
    tick();
    chk("p1_cnt", 64'(pair_cnt), 64'd1);
    chk("p1_popped", 64'(out_valid), 64'd0);

    // Odd burst of three words
    in_valid = 1'b1; in_data = 32'hA0A0_A0A0; in_last = 1'b0;
    tick();
    in_data = 32'hA1A1_A1A1;
    tick();
    chk_pair("odd_a", 32'hA0A0_A0A0, 32'hA1A1_A1A1, 2'b11, 1'b0);
    in_data = 32'hA2A2_A2A2; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk_pair("odd_b", 32'hA2A2_A2A2, 32'h0, 2'b01, 1'b1);
    chk("odd_cnt_mid", 64'(pair_cnt), 64'd2);
    tick();
    chk("odd_cnt", 64'(pair_cnt), 64'd3);

    // Continuous 8-word stream, one word per cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i); in_last = 1'b0;
      #1;
      chk("str_in_ready", 64'(in_ready), 64'd1);
      tick();
      if (i % 2 == 1) chk_pair("str", 32'h100 + 32'(i - 1), 32'h100 + 32'(i), 2'b11, 1'b0);
      else chk("str_half", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("str_cnt", 64'(pair_cnt), 64'd7);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB000_0000;
    tick();
    in_data = 32'hB000_0001;
    tick();
    in_data = 32'hB000_0002;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk_pair("bp_hold", 32'hB000_0000, 32'hB000_0001, 2'b11, 1'b0);
      tick();
    end
    chk("bp_cnt_held", 64'(pair_cnt), 64'd7);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_pop_acc_valid", 64'(out_valid), 64'd0);
    chk("bp_pop_acc_keep", 64'(out_keep), 64'd0);
    chk("bp_pop_cnt", 64'(pair_cnt), 64'd8);
    in_data = 32'hB000_0003;
    tick();
    in_valid = 1'b0;
    chk_pair("bp_next", 32'hB000_0002, 32'hB000_0003, 2'b11, 1'b0);
    tick();
    chk("bp_cnt", 64'(pair_cnt), 64'd9);

    // Reset mid-burst
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(pair_cnt), 64'd0);
    chk("mid_rst_d0", 64'(out_data[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    chk("mid_after_half", 64'(out_valid), 64'd0);
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    chk_pair("mid_pair", 32'h1, 32'h2, 2'b11, 1'b0);
    tick();
    chk("mid_cnt", 64'(pair_cnt), 64'd1);
    chk("mid_cnt4", 64'(pair_cnt4), 64'd1);

    // Saturation: single-word bursts back to back, one pop per cycle after the first
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'hC000_0000 + 32'(i); in_last = 1'b1;
      tick();
      chk_pair("sat_tail", 32'hC000_0000 + 32'(i), 32'h0, 2'b01, 1'b1);
      chk("sat_cnt", 64'(pair_cnt), 64'(1 + i));
      chk("sat_cnt4", 64'(pair_cnt4), 64'((1 + i) > 15 ? 15 : (1 + i)));
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("sat_final_cnt", 64'(pair_cnt), 64'd17);
    chk("sat_final_cnt4", 64'(pair_cnt4), 64'd15);
    chk("sat_final_valid4", 64'(out_valid4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_pair_packer.md
Name: word_pair_packer

Overview:
- Serial-to-pair packer that sits directly upstream of the pair-consuming stage, which takes an unpacked `[DW-1:0] dd[2]` port.
- Accepts a valid/ready stream of single DW-bit words and assembles consecutive words into a 2-element unpacked array output.
- Lane 0 is the earlier word and lane 1 the later word.
- Handles odd-length bursts via `in_last`, with lane masking and zero padding.
- Sustains one input word per cycle when downstream is always ready.

Parameters:
- `DW`, 32, word width of each lane.
- `CNT_W`, 16, width of the emitted-pair statistics counter.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  packer can accept a word this cycle.
- `in_data`  input  DW  upstream word.
- `in_last`  input  1  word is the final word of a burst.
- `out_valid`  output  1  pair valid.
- `out_ready`  input  1  downstream accepts pair.
- `out_data`  output  DW x 2 (unpacked `[DW-1:0] out_data[2]`)  packed pair; `[0]` is the earlier word.
- `out_keep`  output  2  lane valid mask; 2'b11 for a full pair, 2'b01 for an odd tail.
- `out_last`  output  1  pair closes a burst.
- `pair_cnt`  output  CNT_W  number of pairs handed off (`out_valid & out_ready`), saturating.

Behaviour:
- Reset (`rst_n` low, async assert, sync deassert by design convention):
  - state = EMPTY.
  - `out_valid`, `out_keep`, `out_last`, `pair_cnt` = 0.
  - `out_data[0]`, `out_data[1]` = 0.
  - `in_ready` = 1 once out of reset.
- Transfer events:
  - acc = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- `in_ready` = (state != FULL) | `out_ready`. This is combinational from `out_ready`, with no skid.
- States:
  - EMPTY: `out_valid`=0.
    - acc with `in_last`=0 -> `out_data[0]`=`in_data`, go HALF.
    - acc with `in_last`=1 -> `out_data[0]`=`in_data`, `out_data[1]`=0, keep=01, last=1, go FULL.
  - HALF: `out_valid`=0, lane 0 held.
    - acc -> `out_data[1]`=`in_data`, keep=11, last=`in_last`, go FULL.
  - FULL: `out_valid`=1; data, keep and last are stable until pop.
    - pop without acc -> clear keep/last, go EMPTY. Data registers hold their value (don't-care).
    - pop with acc -> behave as EMPTY accepting the word: go HALF, or FULL with keep=01 if `in_last`.
    - no pop -> hold, `in_ready`=0.
- Latency: a word accepted at edge N that completes a pair gives `out_valid`=1 in the cycle after edge N. Back-to-back throughput is 1 word/cycle, 1 pair/2 cycles.
- Tail padding: an unused lane is always driven 0, never stale data.
- `in_last` while in HALF closes the burst with a full pair (keep=11, last=1). EMPTY-with-last produces a single-lane pair.
- `pair_cnt`: +1 on every pop; saturates at all-ones and does not wrap.
- Inputs sampled while `in_ready`=0 are ignored; the upstream holds data per valid/ready rules.
- `out_valid` never deasserts without a pop. Data does not change while `out_valid` & !`out_ready`.
- Reset mid-burst: any half-assembled word is discarded, with no output produced for it.
- Assertions:
  - `out_keep` ∈ {00 when !`out_valid`, 01, 11}.
  - `out_keep`==01 implies `out_last`.

Decomposition:
- `word_pair_pkg`:
  - `PAIR_LANES`=2.
  - `typedef enum logic [1:0] {EMPTY, HALF, FULL} pack_state_t`.
  - keep constants `KEEP_ONE`=2'b01, `KEEP_BOTH`=2'b11.
- No sub-module; the block is a single FSM plus output registers.
- The saturating counter may be a local always block.

Test Plan:
- Reset then stream 0x11111111, 0x22222222 with `out_ready`=1 -> one pair: `out_data`='{0x11111111,0x22222222}, keep=11, last=0, `pair_cnt`=1.
- Odd burst of 3 words A0,A1,A2 (last on A2), `out_ready`=1 -> pairs '{A0,A1}/keep=11/last=0, then '{A2,0}/keep=01/last=1; `pair_cnt`=2.
- Continuous 8-word stream, `in_valid`=1, `out_ready`=1 -> `in_ready` never low, 4 pairs on alternate cycles, zero dropped words.
- Backpressure: pair ready, `out_ready`=0 for 5 cycles -> `in_ready`=0, `out_data`/keep/last stable. Then `out_ready`=1 with next word valid -> pop and accept in the same cycle, state HALF.
- Reset mid-burst: accept 0xDEADBEEF (HALF), assert `rst_n`=0 -> `out_valid`=0, `pair_cnt`=0. After release, 0x1,0x2 produce '{0x1,0x2}, with no trace of 0xDEADBEEF.
- `CNT_W`=4 build: 17 pops -> `pair_cnt` holds 15 and does not wrap.
